// File: rtl/sand_sweep_if.sv
// Grid RAM port plus the physics-stage operand/result bundle of the sand sweeper.
// master: the sweeper; slave: the RAM arbiter / physics-stage side.
interface sand_sweep_if #(
    parameter int ADDR_W = 15
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic [31:0]       mem_rdata;

    logic              upd_screenbegin;
    logic              upd_screenend;
    logic              upd_screenbottom;
    logic [31:0]       upd_region;
    logic [31:0]       upd_floor;
    logic [31:0]       upd_new_region;
    logic [31:0]       upd_new_floor;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata,
        output upd_screenbegin, upd_screenend, upd_screenbottom,
        output upd_region, upd_floor,
        input  upd_new_region, upd_new_floor
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata,
        input  upd_screenbegin, upd_screenend, upd_screenbottom,
        input  upd_region, upd_floor,
        output upd_new_region, upd_new_floor
    );
endinterface

// File: rtl/sand_sweep.sv
// Frame sequencer for the packed sand grid: for every 16-pixel word it reads the
// region word and the word below it, hands both to the physics stage, and writes
// the two results back. The bottom row uses an all-WALL floor and skips the floor
// read/write.
module sand_sweep #(
    parameter int ROW_WORDS = 40,
    parameter int ROWS      = 480,
    parameter int ADDR_W    = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    sand_sweep_if.master bus
);
    localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_WORDS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_WORDS);

    typedef enum logic [3:0] {
        IDLE,
        RD_R,
        CAP_R,
        RD_F,
        CAP_F,
        CALC,
        WR_R,
        WR_F,
        ADV
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wb_floor;

    logic              at_end;
    logic              at_bottom;
    logic [ADDR_W-1:0] region_addr;
    logic [ADDR_W-1:0] floor_addr;

    // Position decode and address generation from the registered row/col/base.
    always_comb begin
        at_end      = (col == LAST_COL);
        at_bottom   = (row == LAST_ROW);
        region_addr = base + ADDR_W'(col);
        floor_addr  = region_addr + ROW_STEP;
    end

    assign bus.upd_screenbegin  = (col == '0);
    assign bus.upd_screenend    = at_end;
    assign bus.upd_screenbottom = at_bottom;

    // Sweep state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            base           <= '0;
            wb_floor       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.upd_region <= '0;
            bus.upd_floor  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row          <= '0;
                        col          <= '0;
                        base         <= '0;
                        busy         <= 1'b1;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= '0;
                        state        <= RD_R;
                    end
                end
                RD_R: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= CAP_R;
                    end
                end
                CAP_R: begin
                    bus.upd_region <= bus.mem_rdata;
                    if (at_bottom) begin
                        bus.upd_floor <= '1;
                        state         <= CALC;
                    end else begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= floor_addr;
                        state        <= RD_F;
                    end
                end
                RD_F: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= CAP_F;
                    end
                end
                CAP_F: begin
                    bus.upd_floor <= bus.mem_rdata;
                    state         <= CALC;
                end
                CALC: begin
                    // New region goes straight into the write-data register; only
                    // the floor result needs holding until the second write.
                    wb_floor      <= bus.upd_new_floor;
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= region_addr;
                    bus.mem_wdata <= bus.upd_new_region;
                    state         <= WR_R;
                end
                WR_R: begin
                    if (bus.mem_gnt) begin
                        if (at_bottom) begin
                            bus.mem_req <= 1'b0;
                            bus.mem_we  <= 1'b0;
                            done        <= at_end;
                            state       <= ADV;
                        end else begin
                            bus.mem_addr  <= floor_addr;
                            bus.mem_wdata <= wb_floor;
                            state         <= WR_F;
                        end
                    end
                end
                WR_F: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= ADV;
                    end
                end
                ADV: begin
                    if (at_bottom && at_end) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (at_end) begin
                            col  <= '0;
                            row  <= row + 1'b1;
                            base <= base + ROW_STEP;
                        end else begin
                            col <= col + 1'b1;
                        end
                        // Next region word is always the current one plus one,
                        // whether or not the row wraps.
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= region_addr + ADDR_W'(1);
                        state        <= RD_R;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sand_sweep.sv
// Bench for sand_sweep on a 2x3-word grid with a behavioural RAM and a small
// per-pixel physics stage (01=SAND, 10=SAND_AM, 11=WALL).
module tb_sand_sweep;
    localparam int RW = 2;
    localparam int RS = 3;
    localparam int AW = 15;
    localparam int NW = RW * RS;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          sb;
        logic          se;
        logic          sbot;
        logic          wall;
    } acc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic gnt = 1'b1;
    logic [31:0] rdata = '0;
    logic [31:0] ram [0:NW-1];
    logic [31:0] nr, nf;

    acc_t log_q[$];
    acc_t vec[$];
    int   done_cnt = 0;
    int   total = 0;
    int   bad = 0;

    sand_sweep_if #(.ADDR_W(AW)) bus ();

    sand_sweep #(.ROW_WORDS(RW), .ROWS(RS), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_gnt   = gnt;
    assign bus.mem_rdata = rdata;

    // Physics stage stub: SAND over an empty floor pixel falls and becomes
    // SAND_AM; SAND_AM in a region settles back to SAND.
    always_comb begin
        nr = bus.upd_region;
        nf = bus.upd_floor;
        for (int i = 0; i < 16; i++) begin
            if (bus.upd_region[2*i +: 2] == 2'b01 && bus.upd_floor[2*i +: 2] == 2'b00) begin
                nr[2*i +: 2] = 2'b00;
                nf[2*i +: 2] = 2'b10;
            end else if (bus.upd_region[2*i +: 2] == 2'b10) begin
                nr[2*i +: 2] = 2'b01;
            end
        end
    end
    assign bus.upd_new_region = nr;
    assign bus.upd_new_floor  = nf;

    // RAM model and access logger.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (reset_n && bus.mem_req && bus.mem_gnt) begin
            acc_t a;
            a.addr = bus.mem_addr;
            a.we   = bus.mem_we;
            a.sb   = bus.upd_screenbegin;
            a.se   = bus.upd_screenend;
            a.sbot = bus.upd_screenbottom;
            a.wall = (bus.upd_floor == 32'hFFFF_FFFF);
            log_q.push_back(a);
            if (int'(bus.mem_addr) < NW) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            rdata <= ram[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int addr, input bit we, input bit sb, input bit se,
                                input bit sbot, input bit wall);
        acc_t a;
        a.addr = AW'(addr);
        a.we   = we;
        a.sb   = sb;
        a.se   = se;
        a.sbot = sbot;
        a.wall = wall;
        vec.push_back(a);
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < NW; i++) ram[i] = '0;
    endtask

    task automatic check_ram(input string tag, input logic [31:0] w0, input logic [31:0] w2);
        for (int i = 0; i < NW; i++)
            chk($sformatf("%s_ram%0d", tag, i), ram[i], (i == 0) ? w0 : (i == 2) ? w2 : 32'h0);
    endtask

    task automatic check_seq(input string tag, input int from);
        chk({tag, "_len"}, log_q.size() - from, vec.size());
        for (int i = 0; i < vec.size() && from + i < log_q.size(); i++) begin
            acc_t g;
            g = log_q[from + i];
            chk($sformatf("%s_acc%0d", tag, i), {g.addr, g.we, g.sb, g.se, g.sbot},
                {vec[i].addr, vec[i].we, vec[i].sb, vec[i].se, vec[i].sbot});
            if (vec[i].we)
                chk($sformatf("%s_floorwall%0d", tag, i), g.wall, vec[i].wall);
        end
    endtask

    // One sweep: optional second start at cycle restart_at, optional grant stall
    // on the first write. lat is the cycle (1 = first after the start edge) in
    // which done is seen.
    task automatic run_sweep(input int restart_at, input int stall_n, output int lat);
        int cyc;
        bit stalled;
        stalled = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            start = (cyc == restart_at);
            if (stall_n > 0 && !stalled && bus.mem_req && bus.mem_we) begin
                gnt = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    cyc++;
                    chk("stall_req", bus.mem_req, 1'b1);
                    chk("stall_we", bus.mem_we, 1'b1);
                    chk("stall_addr", bus.mem_addr, 0);
                    chk("stall_wdata", bus.mem_wdata, 32'hC000_0000);
                end
                gnt = 1'b1;
                stalled = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("busy_at_done", busy, 1'b1);
        lat = cyc;
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        int n0;
        int d0;

        // Expected access order for the 2x3 grid with flags; wall only on
        // bottom-row writes.
        add(0,0,1,0,0,0); add(2,0,1,0,0,0); add(0,1,1,0,0,0); add(2,1,1,0,0,0);
        add(1,0,0,1,0,0); add(3,0,0,1,0,0); add(1,1,0,1,0,0); add(3,1,0,1,0,0);
        add(2,0,1,0,0,0); add(4,0,1,0,0,0); add(2,1,1,0,0,0); add(4,1,1,0,0,0);
        add(3,0,0,1,0,0); add(5,0,0,1,0,0); add(3,1,0,1,0,0); add(5,1,0,1,0,0);
        add(4,0,1,0,1,0); add(4,1,1,0,1,1);
        add(5,0,0,1,1,0); add(5,1,0,1,1,1);

        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_region", bus.upd_region, 0);
        chk("rst_floor", bus.upd_floor, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero grid: order, flags, latency, RAM untouched.
        n0 = log_q.size();
        d0 = done_cnt;
        run_sweep(0, 0, lat);
        chk("t1_latency", lat, 42);
        chk("t1_done_cnt", done_cnt - d0, 1);
        check_seq("t1", n0);
        check_ram("t1", 32'h0, 32'h0);

        // One SAND pixel falls one row per frame.
        clear_ram();
        ram[0] = 32'h4000_0000;
        run_sweep(0, 0, lat);
        chk("t2_latency", lat, 42);
        check_ram("t2", 32'h0, 32'h4000_0000);

        // Grant stall on first region write (WALL pixel keeps wdata nonzero).
        clear_ram();
        ram[0] = 32'hC000_0000;
        run_sweep(0, 5, lat);
        chk("t3_latency", lat, 47);
        check_ram("t3", 32'hC000_0000, 32'h0);

        // Second start mid-sweep is ignored.
        clear_ram();
        n0 = log_q.size();
        d0 = done_cnt;
        run_sweep(10, 0, lat);
        chk("t4_latency", lat, 42);
        chk("t4_done_cnt", done_cnt - d0, 1);
        check_seq("t4", n0);

        // Reset mid-sweep abandons it.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("t5_busy_before", busy, 1'b1);
        n0 = log_q.size();
        d0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_req", bus.mem_req, 1'b0);
        chk("t5_done", done, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_no_access", log_q.size() - n0, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle", busy, 1'b0);

        // Fresh sweep after the abandoned one.
        clear_ram();
        n0 = log_q.size();
        run_sweep(0, 0, lat);
        chk("t5_restart_latency", lat, 42);
        check_seq("t5r", n0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
